// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: stall encodings, FSM states and reset level shared by the pipeline controller.
package pipe_ctrl_pkg;
    localparam logic        RstEnable    = 1'b0;
    localparam logic [5:0]  StallNone    = 6'b000000;
    localparam logic [5:0]  StallIf      = 6'b000011;
    localparam logic [5:0]  StallId      = 6'b000111;
    localparam logic [5:0]  StallEx      = 6'b001111;
    localparam logic [5:0]  StallAll     = 6'b111111;
    localparam logic [31:0] ExcVectorDef = 32'h0000_0020;
    typedef enum logic [1:0] {RUN, FREEZE, FLUSH} state_t;
endpackage

// File: rtl/pipe_ctrl_stall_mon.sv
// pipe_ctrl_stall_mon: stall-cycle perf counter and sticky stuck-stall watchdog.
module pipe_ctrl_stall_mon
    import pipe_ctrl_pkg::*;
#(
    parameter int MAX_STALL = 16,
    parameter int CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stalled,
    output logic [CNT_W-1:0] stall_cycles,
    output logic             stall_timeout
);
    localparam int RW = $clog2(MAX_STALL + 1);

    logic [RW-1:0] run_len;

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstEnable) begin
            stall_cycles  <= '0;
            run_len       <= '0;
            stall_timeout <= 1'b0;
        end else begin
            stall_cycles  <= stall_cycles + CNT_W'(stalled);
            run_len       <= !stalled ? '0 : run_len == RW'(MAX_STALL) ? run_len : run_len + RW'(1);
            // sets on the edge that completes the MAX_STALL-th consecutive stalled cycle
            stall_timeout <= stall_timeout | (stalled && run_len >= RW'(MAX_STALL - 1));
        end
    end
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: merges stage stall requests and sequences exception/ERET redirects
// through a one-cycle freeze followed by a one-cycle flush.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = ExcVectorDef,
    parameter int          MAX_STALL  = 16,
    parameter int          CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stallreq_if,
    input  logic             stallreq_id,
    input  logic             stallreq_ex,
    input  logic             excp_valid,
    input  logic             excp_eret,
    input  logic [31:0]      cp0_epc,
    output logic [5:0]       stall,
    output logic             flush,
    output logic [31:0]      new_pc,
    output logic             new_pc_valid,
    output logic [CNT_W-1:0] stall_cycles,
    output logic             stall_timeout
);
    state_t     state;
    logic [5:0] run_stall;

    always_comb begin
        run_stall = excp_valid  ? StallAll :
                    stallreq_ex ? StallEx  :
                    stallreq_id ? StallId  :
                    stallreq_if ? StallIf  : StallNone;
    end

    assign stall = state == RUN ? run_stall : state == FREEZE ? StallAll : StallNone;

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstEnable) begin
            state        <= RUN;
            flush        <= 1'b0;
            new_pc       <= '0;
            new_pc_valid <= 1'b0;
        end else begin
            flush        <= state == FREEZE;
            new_pc_valid <= state == FREEZE;
            case (state)
                RUN: if (excp_valid) begin
                    new_pc <= excp_eret ? cp0_epc : EXC_VECTOR;
                    state  <= FREEZE;
                end
                FREEZE:  state <= FLUSH;
                default: state <= RUN;
            endcase
        end
    end

    pipe_ctrl_stall_mon #(
        .MAX_STALL(MAX_STALL),
        .CNT_W    (CNT_W)
    ) u_mon (
        .clk          (clk),
        .rst          (rst),
        .stalled      (stall != StallNone),
        .stall_cycles (stall_cycles),
        .stall_timeout(stall_timeout)
    );
endmodule
